// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the 8-bit LFSR stream cipher (encryptor and decryptor).
// Holds the LFSR polynomial, the frame state encoding and the keystream helpers.
package stream_cipher_pkg;

  localparam logic [7:0] LFSR_RESET = 8'h01;

  // Feedback taps of the 8-bit LFSR: new bit = t[7] ^ t[5] ^ t[4] ^ t[3]
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } frame_state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] t);
    return {t[6:0], t[TAP_A] ^ t[TAP_B] ^ t[TAP_C] ^ t[TAP_D]};
  endfunction

  // Keystream bit i is the LSB of the LFSR before its i-th shift.
  function automatic logic [7:0] keystream_byte(input logic [7:0] lfsr);
    logic [7:0] t;
    logic [7:0] ks;
    t  = lfsr;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i] = t[0];
      t     = lfsr_step(t);
    end
    return ks;
  endfunction

  function automatic logic [7:0] lfsr_advance8(input logic [7:0] lfsr);
    logic [7:0] t;
    t = lfsr;
    for (int i = 0; i < 8; i++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

endpackage

// File: rtl/stream_decipher_rx_if.sv
// Byte stream with ready/valid handshake; master drives data/valid, slave drives ready.
interface stream_decipher_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_decipher_rx_keystream.sv
// Combinational keystream generator: one byte of keystream and the LFSR state
// that follows it. Shared with the transmit-side encryptor.
module stream_keystream_gen
  import stream_cipher_pkg::*;
(
  input  logic [7:0] lfsr,
  output logic [7:0] ks,
  output logic [7:0] lfsr_next
);

  always_comb begin
    ks        = keystream_byte(lfsr);
    lfsr_next = lfsr_advance8(lfsr);
  end

endmodule

// File: rtl/stream_decipher_rx.sv
// Receive-side stream decipher: decrypts framed ciphertext (length header,
// payload, optional XOR trailer) and forwards payload bytes over ready/valid.
module stream_decipher_rx
  import stream_cipher_pkg::*;
#(
  parameter logic [7:0] LFSR_INIT = LFSR_RESET,
  parameter bit         CHECK_EN  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  seed,
  input  logic                        load,
  stream_decipher_rx_if.slave         ct,
  stream_decipher_rx_if.master        pt,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);

  frame_state_t state_reg, state_next;
  logic [7:0]   lfsr_reg, lfsr_next;
  logic [7:0]   count_reg, count_next;
  logic [7:0]   csum_reg, csum_next;
  logic [7:0]   pt_data_reg, pt_data_next;
  logic         pt_valid_reg, pt_valid_next;
  logic         frame_done_reg, frame_done_next;
  logic         frame_err_reg, frame_err_next;

  logic [7:0]   ks;
  logic [7:0]   lfsr_adv;
  logic [7:0]   plain_byte;
  logic         ct_ready_int;
  logic         ct_fire;

  stream_keystream_gen u_keystream (
    .lfsr      (lfsr_reg),
    .ks        (ks),
    .lfsr_next (lfsr_adv)
  );

  assign plain_byte = ct.data ^ ks;

  // Payload acceptance only stalls when the single output slot is full and not draining.
  always_comb begin
    ct_ready_int = 1'b0;
    if (!load) begin
      case (state_reg)
        HDR:     ct_ready_int = 1'b1;
        PAYLOAD: ct_ready_int = !pt_valid_reg || pt.ready;
        CHECK:   ct_ready_int = 1'b1;
        default: ct_ready_int = 1'b0;
      endcase
    end
  end

  assign ct_fire = ct.valid && ct_ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HDR;
      lfsr_reg       <= LFSR_INIT;
      count_reg      <= '0;
      csum_reg       <= '0;
      pt_data_reg    <= '0;
      pt_valid_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= lfsr_next;
      count_reg      <= count_next;
      csum_reg       <= csum_next;
      pt_data_reg    <= pt_data_next;
      pt_valid_reg   <= pt_valid_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lfsr_next       = lfsr_reg;
    count_next      = count_reg;
    csum_next       = csum_reg;
    pt_data_next    = pt_data_reg;
    pt_valid_next   = pt_valid_reg && !pt.ready;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;

    if (load) begin
      lfsr_next     = seed;
      state_next    = HDR;
      pt_valid_next = 1'b0;
      csum_next     = '0;
    end else if (ct_fire) begin
      lfsr_next = lfsr_adv;
      case (state_reg)
        HDR: begin
          count_next = plain_byte;
          csum_next  = '0;
          if (plain_byte != 8'd0) begin
            state_next = PAYLOAD;
          end else if (CHECK_EN) begin
            state_next = CHECK;
          end else begin
            frame_done_next = 1'b1;
          end
        end
        PAYLOAD: begin
          pt_data_next  = plain_byte;
          pt_valid_next = 1'b1;
          csum_next     = csum_reg ^ plain_byte;
          count_next    = count_reg - 8'd1;
          if (count_reg == 8'd1) begin
            if (CHECK_EN) begin
              state_next = CHECK;
            end else begin
              state_next      = HDR;
              frame_done_next = 1'b1;
            end
          end
        end
        CHECK: begin
          state_next      = HDR;
          frame_done_next = 1'b1;
          frame_err_next  = (plain_byte != csum_reg);
        end
        default: state_next = HDR;
      endcase
    end
  end

  assign ct.ready   = ct_ready_int;
  assign pt.data    = pt_data_reg;
  assign pt.valid   = pt_valid_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg == PAYLOAD) || (state_reg == CHECK);

endmodule

// File: tb/tb_stream_decipher_rx.sv
// Directed bench for stream_decipher_rx: one DUT with the checksum trailer,
// one without, driven with hand-computed ciphertext frames.
module tb_stream_decipher_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       load = 1'b0;
  logic       load2 = 1'b0;
  logic       frame_done, frame_err, busy;
  logic       frame_done2, frame_err2, busy2;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];

  always #5 clk = ~clk;

  stream_decipher_rx_if ct_a ();
  stream_decipher_rx_if pt_a ();
  stream_decipher_rx_if ct_b ();
  stream_decipher_rx_if pt_b ();

  stream_decipher_rx #(.LFSR_INIT(8'h01), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .seed(seed), .load(load),
    .ct(ct_a), .pt(pt_a),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  stream_decipher_rx #(.LFSR_INIT(8'h01), .CHECK_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .seed(seed), .load(load2),
    .ct(ct_b), .pt(pt_b),
    .frame_done(frame_done2), .frame_err(frame_err2), .busy(busy2)
  );

  // Record every delivered plaintext byte; handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (pt_a.valid && pt_a.ready) rx_a.push_back(pt_a.data);
    if (pt_b.valid && pt_b.ready) rx_b.push_back(pt_b.data);
  end

  task automatic send(input bit sel, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (sel == 1'b0) begin ct_a.valid = 1'b1; ct_a.data = b; end
    else             begin ct_b.valid = 1'b1; ct_b.data = b; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((sel == 1'b0 && ct_a.ready) || (sel == 1'b1 && ct_b.ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (sel == 1'b0) ct_a.valid = 1'b0; else ct_b.valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ct_accept: byte %h got ct_ready=0 for 50 cycles, required 1", b);
    end
    $display("tx dut%0d ct=%h accepted=%0d", sel, b, ok);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Frame 02 | 48 69 | trailer, from LFSR 01; trailer B2 is the correct checksum.
  task automatic run_frame1(input logic [7:0] trailer, input logic exp_err, input string tag);
    int base;
    base = rx_a.size();
    send(1'b0, 8'h73);
    send(1'b0, 8'hEC);
    send(1'b0, 8'h6A);
    send(1'b0, trailer);
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_done: got %b required 1", tag, frame_done);
    end
    vectors++;
    if (frame_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s frame_err: got %b required %b", tag, frame_err, exp_err);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after: got %b required 0", tag, busy);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse_width: got done=%b err=%b required 0 0", tag, frame_done, frame_err);
    end
    vectors++;
    if (rx_a.size() - base != 2) begin
      miscompares++;
      $display("FAIL %s byte_count: got %0d required 2", tag, rx_a.size() - base);
    end
    vectors++;
    if (rx_a[base] !== 8'h48) begin
      miscompares++;
      $display("FAIL %s pt0: got %h required 48", tag, rx_a[base]);
    end
    vectors++;
    if (rx_a[base+1] !== 8'h69) begin
      miscompares++;
      $display("FAIL %s pt1: got %h required 69", tag, rx_a[base+1]);
    end
    vectors++;
    if (dut.lfsr_reg !== 8'h92) begin
      miscompares++;
      $display("FAIL %s final_lfsr: got %h required 92", tag, dut.lfsr_reg);
    end
    $display("frame %s done", tag);
  endtask

  task automatic test_reset();
    ct_a.valid = 1'b0; ct_a.data = 8'h00; pt_a.ready = 1'b1;
    ct_b.valid = 1'b0; ct_b.data = 8'h00; pt_b.ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (pt_a.valid !== 1'b0 || pt_a.data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_pt: got valid=%b data=%h required 0 00", pt_a.valid, pt_a.data);
    end
    vectors++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got done=%b err=%b busy=%b required 0 0 0", frame_done, frame_err, busy);
    end
    vectors++;
    if (ct_a.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ct_ready: got %b required 1", ct_a.ready);
    end
    vectors++;
    if (dut.lfsr_reg !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_lfsr: got %h required 01", dut.lfsr_reg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_good_frame();
    do_reset();
    run_frame1(8'hB2, 1'b0, "good");
  endtask

  task automatic test_bad_checksum();
    do_reset();
    run_frame1(8'hB3, 1'b1, "badsum");
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    base = rx_a.size();
    send(1'b0, 8'h73);
    send(1'b0, 8'hEC);
    pt_a.ready = 1'b0;
    ct_a.valid = 1'b1;
    ct_a.data  = 8'h6A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (pt_a.valid !== 1'b1 || pt_a.data !== 8'h48) begin
        miscompares++;
        $display("FAIL stall%0d_hold: got valid=%b data=%h required 1 48", i, pt_a.valid, pt_a.data);
      end
      vectors++;
      if (ct_a.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d_ct_ready: got %b required 0", i, ct_a.ready);
      end
    end
    @(posedge clk); #1;
    pt_a.ready = 1'b1;
    send(1'b0, 8'h6A);
    send(1'b0, 8'hB2);
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_done: got done=%b err=%b required 1 0", frame_done, frame_err);
    end
    @(negedge clk);
    vectors++;
    if (rx_a.size() - base != 2 || rx_a[base] !== 8'h48 || rx_a[base+1] !== 8'h69) begin
      miscompares++;
      $display("FAIL bp_bytes: got n=%0d %h %h required 2 48 69", rx_a.size() - base, rx_a[base], rx_a[base+1]);
    end
    $display("backpressure frame done");
  endtask

  task automatic test_zero_length();
    int base;
    do_reset();
    base = rx_a.size();
    send(1'b0, 8'h71);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || pt_a.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_hdr: got busy=%b pt_valid=%b required 1 0", busy, pt_a.valid);
    end
    @(posedge clk); #1;
    send(1'b0, 8'hA4);
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: got done=%b err=%b required 1 0", frame_done, frame_err);
    end
    @(negedge clk);
    vectors++;
    if (rx_a.size() != base) begin
      miscompares++;
      $display("FAIL zero_no_pt: got %0d bytes required 0", rx_a.size() - base);
    end
    $display("zero-length frame done");
  endtask

  task automatic test_load_abort();
    int base;
    do_reset();
    base = rx_a.size();
    send(1'b0, 8'h73);
    pt_a.ready = 1'b0;
    send(1'b0, 8'hEC);
    load = 1'b1; seed = 8'h01;
    ct_a.valid = 1'b1; ct_a.data = 8'h6A;
    @(negedge clk);
    vectors++;
    if (ct_a.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_ct_ready: got %b required 0", ct_a.ready);
    end
    @(posedge clk); #1;
    load = 1'b0; ct_a.valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (pt_a.valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clear: got pt_valid=%b busy=%b required 0 0", pt_a.valid, busy);
    end
    vectors++;
    if (rx_a.size() != base) begin
      miscompares++;
      $display("FAIL load_no_pt: got %0d bytes required 0", rx_a.size() - base);
    end
    @(posedge clk); #1;
    pt_a.ready = 1'b1;
    run_frame1(8'hB2, 1'b0, "after_load");
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(1'b0, 8'h73);
    send(1'b0, 8'hEC);
    rst_n = 1'b0;
    #2;
    vectors++;
    if (pt_a.valid !== 1'b0 || busy !== 1'b0 || dut.lfsr_reg !== 8'h01) begin
      miscompares++;
      $display("FAIL midreset: got pt_valid=%b busy=%b lfsr=%h required 0 0 01", pt_a.valid, busy, dut.lfsr_reg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame1(8'hB2, 1'b0, "after_reset");
  endtask

  task automatic test_no_check();
    int base;
    do_reset();
    base = rx_b.size();
    send(1'b1, 8'h73);
    send(1'b1, 8'hEC);
    send(1'b1, 8'h6A);
    @(negedge clk);
    vectors++;
    if (frame_done2 !== 1'b1 || frame_err2 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL nochk_done: got done=%b err=%b busy=%b required 1 0 0", frame_done2, frame_err2, busy2);
    end
    @(negedge clk);
    vectors++;
    if (frame_done2 !== 1'b0) begin
      miscompares++;
      $display("FAIL nochk_pulse: got %b required 0", frame_done2);
    end
    vectors++;
    if (rx_b.size() - base != 2 || rx_b[base] !== 8'h48 || rx_b[base+1] !== 8'h69) begin
      miscompares++;
      $display("FAIL nochk_bytes: got n=%0d %h %h required 2 48 69", rx_b.size() - base, rx_b[base], rx_b[base+1]);
    end
    vectors++;
    if (dut_nc.lfsr_reg !== 8'h81) begin
      miscompares++;
      $display("FAIL nochk_lfsr: got %h required 81", dut_nc.lfsr_reg);
    end
    $display("no-check frame done");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_backpressure();
    test_zero_length();
    test_load_abort();
    test_reset_midframe();
    test_no_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_decipher_rx.md
Name: stream_decipher_rx

Overview:
- Receive-side counterpart of the team's 8-bit LFSR stream cipher encryptor: takes framed ciphertext bytes, regenerates the same keystream, and emits plaintext payload bytes over a ready/valid interface.
- Frame format (all bytes encrypted, keystream advances once per byte): header byte = payload length L (0..255), L payload bytes, then, if CHECK_EN, one trailer byte = XOR of all plaintext payload bytes.
- Sits between the link byte receiver and the message consumer.

Parameters:
- LFSR_INIT, 8'h01, LFSR value after reset.
- CHECK_EN, 1, 1 = trailer checksum byte present and checked; 0 = no trailer.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seed  in  8  key value
- load  in  1  load seed into LFSR, abort current frame
- ct_data  in  8  ciphertext byte
- ct_valid  in  1  ct_data valid
- ct_ready  out  1  block accepts ct_data this cycle
- pt_data  out  8  decrypted payload byte
- pt_valid  out  1  pt_data valid
- pt_ready  in  1  consumer accepts pt_data
- frame_done  out  1  one-cycle pulse, frame complete
- frame_err  out  1  one-cycle pulse with frame_done on checksum mismatch
- busy  out  1  high in PAYLOAD or CHECK state

Behaviour:
- Keystream per accepted byte, from current LFSR value t: repeat i = 0..7 { ks[i] = t[0]; t = {t[6:0], t[7]^t[5]^t[4]^t[3]} }. Decrypted byte = ct_data ^ ks. LFSR <= final t. The LFSR advances only on a ct handshake (ct_valid & ct_ready).
- Reset: LFSR = LFSR_INIT, state HDR, pt_data = 0, pt_valid = 0, frame_done = 0, frame_err = 0, remaining count = 0, running checksum = 0.
- load: highest priority. LFSR <= seed, state <= HDR, pt_valid <= 0, checksum <= 0. Any ct byte presented in the same cycle is not consumed (ct_ready = 0 while load = 1).
- HDR:
  - ct_ready = 1.
  - On handshake: count <= decrypted byte, checksum <= 0.
  - Next state is PAYLOAD if decrypted byte != 0; else CHECK if CHECK_EN; else frame_done pulse and stay in HDR.
- PAYLOAD:
  - ct_ready = !pt_valid | pt_ready (single output register, full throughput).
  - On handshake: pt_data <= decrypted byte, pt_valid <= 1 the next cycle (latency 1), checksum ^= decrypted byte, count decrements.
  - When count reaches 0: go to CHECK if CHECK_EN, else go to HDR and pulse frame_done.
- CHECK:
  - ct_ready = 1.
  - On handshake: frame_done pulses next cycle, and frame_err pulses with it if decrypted byte != checksum. State <= HDR.
- pt_valid holds until pt_ready. pt_data is stable while pt_valid & !pt_ready.
- frame_done may occur while the last payload byte is still held in the output register. It is not gated on the output draining.
- Header and trailer bytes never appear on pt_data.
- Simultaneous output drain and input accept in PAYLOAD is legal: pt_data is replaced in the same cycle.
- Reset mid-frame restores the reset state immediately. A partially received frame is discarded.

Decomposition:
- Package stream_cipher_pkg holds:
  - LFSR_RESET = 8'h01 and the tap constants (bits 7, 5, 4, 3).
  - The frame state enum {HDR, PAYLOAD, CHECK}.
  - Functions keystream_byte(lfsr) and lfsr_advance8(lfsr).
- The encryptor shares this package.
- One sub-module: stream_keystream_gen. It is combinational: 8-bit LFSR in, 8-bit keystream and next LFSR out. It is reused later by the encryptor.

Test Plan:
- Reset, no load (LFSR = 01), pt_ready = 1. Feed ct 73, EC, 6A, B2. Expect ks 71, A4, 03, 93; pt_data 48, 69; frame_done one pulse after B2; frame_err = 0; final LFSR = 92.
- Same stream with trailer B3. Expect pt_data 48, 69, then frame_done and frame_err pulsing together.
- Backpressure: as the first case with pt_ready = 0 for 3 cycles after the first pt_valid. Expect pt_data held at 48, ct_ready = 0 in PAYLOAD, no byte lost, then 69 delivered.
- Zero-length frame from LFSR 01: ct 71 (header 00), then 0xA4 (checksum 00). Expect no pt_valid; frame_done pulse; no err.
- load = 1 mid-payload with seed = 01 and ct_valid = 1 in the same cycle. Expect ct_ready = 0 that cycle, pt_valid cleared, state HDR. Replaying the first case then decodes correctly.
- CHECK_EN = 0: ct 73, EC, 6A. Expect pt_data 48, 69 and frame_done after the 6A handshake.
